weight_loader: RTL and testbench
================================

// Module: weight_loader
// PURPOSE
// Hardware weight-preload transmitter; replaces the bench-side weight-send task.
// Sits at the weight-loader mesh node and drives that node's axis_in port.
// Streams register-file write packets to MVM nodes: tuser (rf_en/opcode/rf_addr) is appended above tdata.
// Accepts one command (dest node, DPE, base addr, length) plus a FIFO of weight words.
// PARAMETERS
// DATAW       512  weight word width (tdata payload, tuser excluded)
// USERW       75   appended tuser width: [8:0] rf_addr, [10:9] opcode, [74:11] rf_en
// DPES        64   DPEs per MVM; width of the one-hot rf_en field
// IDW         2    axis tid width
// DESTW       4    axis tdest width (mesh node id)
// FIFO_DEPTH  16   weight word FIFO depth (power of 2, >=2)
// PORTS
// clk              in   1            single clock
// rst              in   1            synchronous, active-high reset
// cmd_valid        in   1            command present
// cmd_ready        out  1            command accepted when valid&&ready
// cmd_dest         in   DESTW        target MVM node id
// cmd_dpe          in   7            target DPE index
// cmd_base_addr    in   9            first register-file address
// cmd_len          in   10           beats in this command (0..512)
// data_fifo_wen    in   1            push weight word
// data_fifo_wdata  in   DATAW        weight word
// data_fifo_rdy    out  1            FIFO not full; push while low is dropped
// axis_tx_tvalid   out  1            AXI-S valid
// axis_tx_tready   in   1            AXI-S ready
// axis_tx_tdata    out  DATAW+USERW  {tuser, weight word}
// axis_tx_tid      out  IDW          constant 0
// axis_tx_tdest    out  DESTW        = latched cmd_dest
// axis_tx_tlast    out  1            high on the final beat of a command
// done             out  1            1-cycle pulse when a command completes
// cmd_err          out  1            qualifies done: dpe >= DPES
// BEHAVIOUR
// - Reset: cmd_ready=0, tvalid=0, tlast=0, tdata=0, tdest=0, done=0, cmd_err=0, FIFO empty.
//   data_fifo_rdy=0 while rst is high, 1 in the first cycle after reset.
// - Reset mid-command: the command is abandoned, FIFO is flushed, and tvalid is 0 the next cycle. No done pulse.
// - FSM IDLE -> SEND | DRAIN -> FINISH -> IDLE.
// - IDLE:
//   - cmd_ready=1.
//   - On accept, latch dest, dpe, addr=base, and rem=len.
//   - len==0: go to FINISH.
//   - dpe>=DPES: go to DRAIN.
//   - Otherwise: go to SEND.
// - SEND: pop one word when the FIFO is non-empty and the output register is empty or handshaking this cycle.
//   - The popped word is loaded into the output register.
//   - tuser = {1<<dpe, 2'h3, addr}.
//   - tlast = (rem==1).
//   - addr increments mod 512 (0x1FF wraps to 0x000). rem decrements.
//   - When the last word is loaded, go to FINISH.
// - DRAIN: pop and discard rem words at up to 1 per cycle. tvalid stays 0. Then go to FINISH with err set.
// - FINISH: wait until the output register is empty (final beat handshaken). Then pulse done (with cmd_err if err) for 1 cycle and go to IDLE.
// - Output register: while tvalid && !tready, tdata, tdest, and tlast are held stable.
//   - tvalid may not deassert without a handshake.
//   - Throughput is 1 beat/cycle with tready held high.
// - Latency: a word pushed into an empty FIFO in cycle t (SEND state) appears on tvalid in cycle t+2.
// - FIFO:
//   - A simultaneous push and pop when full is allowed only if rdy was high, i.e. rdy reflects full before the pop.
//   - A push while !rdy is dropped.
//   - Words pushed while IDLE wait for the next command.
// - At most one command is in flight; cmd_ready=0 outside IDLE.
// TESTING
// - Basic: cmd(dest=2, dpe=5, base=0, len=4), push 4 words W0..W3, tready=1 ->
//   4 beats, tuser = {1<<5, 2'h3, 0..3}, tdest=2, tlast only on beat 3, done 1 cycle after beat 3.
// - Backpressure: same cmd, tready toggling 1010... ->
//   no beat lost or duplicated, tdata stable while stalled, 4 handshakes total.
// - Wrap: base=0x1FE, len=4 -> rf_addr 0x1FE, 0x1FF, 0x000, 0x001.
// - Edge cmds:
//   - len=0 -> no tvalid, done at 2 cycles after accept.
//   - dpe=64, len=3 with 3 words pushed -> no beats, 3 words discarded, done with cmd_err=1.
// - FIFO full: push 17 words with tready=0 (before cmd) -> rdy low after 16, 17th dropped; cmd len=16 drains exactly 16.
// - Reset mid-stream: assert rst after beat 1 of len=8 -> tvalid=0 next cycle, no done, FIFO empty; a new len=2 cmd then works.

Source files
------------

// File: rtl/weight_loader.sv
// Weight-preload transmitter: takes one command plus a FIFO of weight words and
// streams register-file write beats ({tuser, word}) to an MVM node's AXI-S input.
module weight_loader #(
    parameter int DATAW      = 512,
    parameter int USERW      = 75,
    parameter int DPES       = 64,
    parameter int IDW        = 2,
    parameter int DESTW      = 4,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [DESTW-1:0]       cmd_dest,
    input  logic [6:0]             cmd_dpe,
    input  logic [8:0]             cmd_base_addr,
    input  logic [9:0]             cmd_len,

    input  logic                   data_fifo_wen,
    input  logic [DATAW-1:0]       data_fifo_wdata,
    output logic                   data_fifo_rdy,

    output logic                   axis_tx_tvalid,
    input  logic                   axis_tx_tready,
    output logic [DATAW+USERW-1:0] axis_tx_tdata,
    output logic [IDW-1:0]         axis_tx_tid,
    output logic [DESTW-1:0]       axis_tx_tdest,
    output logic                   axis_tx_tlast,

    output logic                   done,
    output logic                   cmd_err,
    output logic [1:0]             state_dbg
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [7:0] DPES_L = 8'(DPES);

    // Handshakes: cmd and axis_tx transfer in any cycle where valid && ready are
    // both high at the rising edge; valid never depends on ready, and a raised
    // axis_tx_tvalid holds with its payload stable until it is taken.

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEND   = 2'd1,
        S_DRAIN  = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t state;

    logic [DATAW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [CW-1:0]    count;
    logic             fifo_empty;
    logic             fifo_full;
    logic             push;
    logic             pop;
    logic [DATAW-1:0] fifo_rdata;

    logic [DESTW-1:0] dest_q;
    logic [6:0]       dpe_q;
    logic [8:0]       addr_q;
    logic [9:0]       rem_q;
    logic             err_q;

    logic             out_free;
    logic             send_pop;
    logic             drain_pop;
    logic             cmd_fire;
    logic             cmd_bad;
    logic [DPES-1:0]  rf_en;
    logic [USERW-1:0] tuser;

    assign fifo_empty    = (count == '0);
    assign fifo_full     = (count == CW'(FIFO_DEPTH));
    // Ready reflects occupancy before any same-cycle pop.
    assign data_fifo_rdy = !rst && !fifo_full;
    assign push          = data_fifo_wen && data_fifo_rdy;
    assign fifo_rdata    = mem[rptr];

    assign out_free  = !axis_tx_tvalid || axis_tx_tready;
    assign send_pop  = (state == S_SEND) && !fifo_empty && out_free;
    assign drain_pop = (state == S_DRAIN) && !fifo_empty && (rem_q != 10'd0);
    assign pop       = send_pop || drain_pop;

    assign cmd_fire = cmd_valid && cmd_ready;
    assign cmd_bad  = ({1'b0, cmd_dpe} >= DPES_L);

    assign rf_en = DPES'(1) << dpe_q;
    assign tuser = {rf_en, 2'h3, addr_q};

    assign axis_tx_tid = '0;
    assign state_dbg   = state;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= data_fifo_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            cmd_ready      <= 1'b0;
            axis_tx_tvalid <= 1'b0;
            axis_tx_tlast  <= 1'b0;
            axis_tx_tdata  <= '0;
            axis_tx_tdest  <= '0;
            done           <= 1'b0;
            cmd_err        <= 1'b0;
            dest_q         <= '0;
            dpe_q          <= '0;
            addr_q         <= '0;
            rem_q          <= '0;
            err_q          <= 1'b0;
        end else begin
            done    <= 1'b0;
            cmd_err <= 1'b0;

            // A taken beat empties the output register unless SEND reloads it below.
            if (axis_tx_tvalid && axis_tx_tready) begin
                axis_tx_tvalid <= 1'b0;
                axis_tx_tlast  <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_fire) begin
                        cmd_ready <= 1'b0;
                        dest_q    <= cmd_dest;
                        dpe_q     <= cmd_dpe;
                        addr_q    <= cmd_base_addr;
                        rem_q     <= cmd_len;
                        err_q     <= cmd_bad;
                        if (cmd_len == 10'd0) begin
                            state <= S_FINISH;
                        end else if (cmd_bad) begin
                            state <= S_DRAIN;
                        end else begin
                            state <= S_SEND;
                        end
                    end
                end

                S_SEND: begin
                    if (send_pop) begin
                        axis_tx_tdata  <= {tuser, fifo_rdata};
                        axis_tx_tdest  <= dest_q;
                        axis_tx_tvalid <= 1'b1;
                        axis_tx_tlast  <= (rem_q == 10'd1);
                        addr_q         <= addr_q + 9'd1;
                        rem_q          <= rem_q - 10'd1;
                        if (rem_q == 10'd1) begin
                            state <= S_FINISH;
                        end
                    end
                end

                // Words for an out-of-range DPE are consumed so the FIFO stays aligned.
                S_DRAIN: begin
                    if (drain_pop) begin
                        rem_q <= rem_q - 10'd1;
                        if (rem_q == 10'd1) begin
                            state <= S_FINISH;
                        end
                    end
                end

                S_FINISH: begin
                    if (out_free) begin
                        done      <= 1'b1;
                        cmd_err   <= err_q;
                        cmd_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_weight_loader.sv
// Directed bench for weight_loader: a table of command scenarios plus hand-written
// sequences for latency, FIFO-full dropping and reset mid-stream.
module tb_weight_loader;

    localparam int DATAW      = 512;
    localparam int USERW      = 75;
    localparam int DPES       = 64;
    localparam int IDW        = 2;
    localparam int DESTW      = 4;
    localparam int FIFO_DEPTH = 16;
    localparam int TW         = DATAW + USERW;
    localparam int EW         = TW + DESTW + 1;

    logic             clk;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [DESTW-1:0] cmd_dest;
    logic [6:0]       cmd_dpe;
    logic [8:0]       cmd_base_addr;
    logic [9:0]       cmd_len;
    logic             data_fifo_wen;
    logic [DATAW-1:0] data_fifo_wdata;
    logic             data_fifo_rdy;
    logic             axis_tx_tvalid;
    logic             axis_tx_tready;
    logic [TW-1:0]    axis_tx_tdata;
    logic [IDW-1:0]   axis_tx_tid;
    logic [DESTW-1:0] axis_tx_tdest;
    logic             axis_tx_tlast;
    logic             done;
    logic             cmd_err;
    logic [1:0]       state_dbg;

    weight_loader #(
        .DATAW(DATAW), .USERW(USERW), .DPES(DPES),
        .IDW(IDW), .DESTW(DESTW), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dest(cmd_dest),
        .cmd_dpe(cmd_dpe), .cmd_base_addr(cmd_base_addr), .cmd_len(cmd_len),
        .data_fifo_wen(data_fifo_wen), .data_fifo_wdata(data_fifo_wdata),
        .data_fifo_rdy(data_fifo_rdy),
        .axis_tx_tvalid(axis_tx_tvalid), .axis_tx_tready(axis_tx_tready),
        .axis_tx_tdata(axis_tx_tdata), .axis_tx_tid(axis_tx_tid),
        .axis_tx_tdest(axis_tx_tdest), .axis_tx_tlast(axis_tx_tlast),
        .done(done), .cmd_err(cmd_err), .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    int cyc = 0;
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    // ---------------- scoreboard state ----------------
    logic [EW-1:0]    exp_q[$];
    logic [DATAW-1:0] word_q[$];
    int vec_cnt = 0;
    int err_cnt = 0;
    int hs_cnt = 0;
    int done_cnt = 0;
    int last_hs_cyc = 0;
    int done_cyc = 0;
    int first_valid_cyc = -1;
    int word_id = 0;
    int bp_mode = 0;
    logic          last_err = 1'b0;
    logic          prev_stall = 1'b0;
    logic          prev_valid = 1'b0;
    logic [EW-1:0] prev_beat = '0;

    task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic logic [DATAW-1:0] mk_word(input int n);
        logic [DATAW-1:0] w;
        for (int i = 0; i < DATAW / 32; i++) begin
            w[i*32 +: 32] = 32'hA500_0000 ^ (32'(n) * 32'h0101_0101 + 32'(i));
        end
        return w;
    endfunction

    function automatic logic [EW-1:0] mk_exp(input logic lst, input logic [3:0] dest,
                                             input logic [6:0] dpe, input logic [8:0] addr,
                                             input logic [DATAW-1:0] w);
        logic [63:0] en;
        en = '0;
        en[dpe[5:0]] = 1'b1;
        return {lst, dest, en, 2'b11, addr, w};
    endfunction

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        logic [EW-1:0] cur;
        cur = {axis_tx_tlast, axis_tx_tdest, axis_tx_tdata};
        if (rst) begin
            prev_stall = 1'b0;
            prev_valid = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid_held", axis_tx_tvalid, 1);
                check("stall_payload_held", cur, prev_beat);
            end
            if (axis_tx_tvalid && !prev_valid) first_valid_cyc = cyc;
            if (axis_tx_tvalid && axis_tx_tready) begin
                hs_cnt++;
                last_hs_cyc = cyc;
                check("beat_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) check("beat", cur, exp_q.pop_front());
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                last_err = cmd_err;
                check("done_all_beats_out", exp_q.size(), 0);
            end
            prev_stall = axis_tx_tvalid && !axis_tx_tready;
            prev_beat  = cur;
            prev_valid = axis_tx_tvalid;
        end
    end

    // tready pattern: 0 = held high, 1 = toggling, 2 = held low.
    initial begin
        axis_tx_tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (bp_mode)
                0:       axis_tx_tready = 1'b1;
                1:       axis_tx_tready = ~axis_tx_tready;
                default: axis_tx_tready = 1'b0;
            endcase
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_words(input int n);
        logic [DATAW-1:0] w;
        for (int i = 0; i < n; i++) begin
            w = mk_word(word_id);
            word_id++;
            word_q.push_back(w);
            data_fifo_wen   = 1'b1;
            data_fifo_wdata = w;
            tick(1);
        end
        data_fifo_wen = 1'b0;
    endtask

    task automatic model_cmd(input logic [3:0] dest, input logic [6:0] dpe,
                             input logic [8:0] base, input int len);
        logic [DATAW-1:0] w;
        for (int i = 0; i < len; i++) begin
            if (word_q.size() == 0) break;
            w = word_q.pop_front();
            if (dpe < 7'(DPES)) exp_q.push_back(mk_exp(i == len - 1, dest, dpe, base + 9'(i), w));
        end
    endtask

    task automatic send_cmd(input logic [3:0] dest, input logic [6:0] dpe,
                            input logic [8:0] base, input int len, output int acc_cyc);
        logic ok;
        ok = 1'b0;
        acc_cyc = -1;
        cmd_valid     = 1'b1;
        cmd_dest      = dest;
        cmd_dpe       = dpe;
        cmd_base_addr = base;
        cmd_len       = 10'(len);
        for (int k = 0; k < 100; k++) begin
            if (cmd_ready) begin
                acc_cyc = cyc;
                ok = 1'b1;
                tick(1);
                break;
            end
            tick(1);
        end
        cmd_valid = 1'b0;
        check("cmd_accepted", ok, 1);
    endtask

    task automatic wait_done(input int start, input int budget);
        for (int k = 0; k < budget; k++) begin
            if (done_cnt != start) break;
            tick(1);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [3:0] dest;
        logic [6:0] dpe;
        logic [8:0] base;
        int         len;
        int         bp;
        int         exp_beats;
        logic       exp_err;
        int         done_ref;   // 0: no timing check, 1: last beat + 1, 2: accept + 2
    } vec_t;

    vec_t vecs[6];

    initial begin
        int acc, h0, d0, t;

        vecs[0] = '{4'd2,  7'd5,  9'h000, 4, 0, 4, 1'b0, 1};
        vecs[1] = '{4'd2,  7'd5,  9'h000, 4, 1, 4, 1'b0, 0};
        vecs[2] = '{4'd7,  7'd63, 9'h1FE, 4, 0, 4, 1'b0, 1};
        vecs[3] = '{4'd1,  7'd0,  9'h010, 0, 0, 0, 1'b0, 2};
        vecs[4] = '{4'd3,  7'd64, 9'h000, 3, 0, 0, 1'b1, 0};
        vecs[5] = '{4'd15, 7'd31, 9'h100, 9, 1, 9, 1'b0, 0};

        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_dest = '0;
        cmd_dpe = '0;
        cmd_base_addr = '0;
        cmd_len = '0;
        data_fifo_wen = 1'b0;
        data_fifo_wdata = '0;
        tick(3);

        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_tvalid", axis_tx_tvalid, 0);
        check("rst_tlast", axis_tx_tlast, 0);
        check("rst_tdata", axis_tx_tdata, 0);
        check("rst_tdest", axis_tx_tdest, 0);
        check("rst_tid", axis_tx_tid, 0);
        check("rst_done", done, 0);
        check("rst_cmd_err", cmd_err, 0);
        check("rst_fifo_rdy_low", data_fifo_rdy, 0);
        check("rst_state_idle", state_dbg, 0);
        rst = 1'b0;
        #1;
        check("post_rst_fifo_rdy", data_fifo_rdy, 1);

        for (int v = 0; v < 6; v++) begin
            bp_mode = vecs[v].bp;
            push_words(vecs[v].len);
            model_cmd(vecs[v].dest, vecs[v].dpe, vecs[v].base, vecs[v].len);
            h0 = hs_cnt;
            d0 = done_cnt;
            send_cmd(vecs[v].dest, vecs[v].dpe, vecs[v].base, vecs[v].len, acc);
            wait_done(d0, 300);
            tick(3);
            check("vec_beats", hs_cnt - h0, vecs[v].exp_beats);
            check("vec_one_done", done_cnt - d0, 1);
            check("vec_cmd_err", last_err, vecs[v].exp_err);
            if (vecs[v].done_ref == 1) check("vec_done_after_last", done_cyc - last_hs_cyc, 1);
            if (vecs[v].done_ref == 2) check("vec_done_after_accept", done_cyc - acc, 2);
        end

        // Latency: word pushed into an empty FIFO while sending shows on tvalid two cycles later.
        bp_mode = 0;
        d0 = done_cnt;
        send_cmd(4'd6, 7'd12, 9'h040, 1, acc);
        tick(2);
        first_valid_cyc = -1;
        t = cyc;
        push_words(1);
        model_cmd(4'd6, 7'd12, 9'h040, 1);
        wait_done(d0, 50);
        tick(2);
        check("latency_push_to_valid", first_valid_cyc - t, 2);
        check("latency_done", done_cnt - d0, 1);

        // FIFO full: 17 pushes with no command, the 17th is dropped.
        bp_mode = 2;
        for (int i = 0; i < 17; i++) begin
            logic [DATAW-1:0] w;
            w = mk_word(word_id);
            word_id++;
            check("fifo_rdy_before_push", data_fifo_rdy, (i < 16) ? 1 : 0);
            if (i < 16) word_q.push_back(w);
            data_fifo_wen   = 1'b1;
            data_fifo_wdata = w;
            tick(1);
        end
        data_fifo_wen = 1'b0;
        check("fifo_rdy_full", data_fifo_rdy, 0);
        bp_mode = 0;
        model_cmd(4'd4, 7'd17, 9'h080, 16);
        h0 = hs_cnt;
        d0 = done_cnt;
        send_cmd(4'd4, 7'd17, 9'h080, 16, acc);
        wait_done(d0, 200);
        tick(2);
        check("full_beats", hs_cnt - h0, 16);
        d0 = done_cnt;
        send_cmd(4'd0, 7'd1, 9'h000, 1, acc);
        tick(8);
        check("full_dropped_word_absent", axis_tx_tvalid, 0);
        push_words(1);
        model_cmd(4'd0, 7'd1, 9'h000, 1);
        wait_done(d0, 50);
        tick(2);
        check("full_followup_done", done_cnt - d0, 1);

        // Reset in the middle of an 8-beat command.
        bp_mode = 0;
        push_words(8);
        model_cmd(4'd5, 7'd9, 9'h020, 8);
        h0 = hs_cnt;
        d0 = done_cnt;
        send_cmd(4'd5, 7'd9, 9'h020, 8, acc);
        for (int k = 0; k < 100; k++) begin
            if (hs_cnt >= h0 + 2) break;
            tick(1);
        end
        check("rst_mid_two_beats", hs_cnt - h0 >= 2, 1);
        rst = 1'b1;
        tick(1);
        check("rst_mid_tvalid_low", axis_tx_tvalid, 0);
        check("rst_mid_rdy_low", data_fifo_rdy, 0);
        check("rst_mid_cmd_ready", cmd_ready, 0);
        rst = 1'b0;
        exp_q.delete();
        word_q.delete();
        #1;
        check("rst_mid_rdy_back", data_fifo_rdy, 1);
        tick(5);
        check("rst_mid_no_done", done_cnt - d0, 0);
        push_words(2);
        model_cmd(4'd8, 7'd40, 9'h1F0, 2);
        h0 = hs_cnt;
        d0 = done_cnt;
        send_cmd(4'd8, 7'd40, 9'h1F0, 2, acc);
        wait_done(d0, 50);
        tick(2);
        check("rst_mid_new_beats", hs_cnt - h0, 2);
        check("rst_mid_new_done", done_cnt - d0, 1);
        check("final_queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
